// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps up to DEPTH word fetches in flight,
// buffers returned words and hands {instr, pc} to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_base_i,
  input  logic [31:0] ImmOp_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i,
  output logic        misalign_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             misalign_q, misalign_d;

  logic [31:0] buf_instr_q [DEPTH];
  logic [31:0] buf_pc_q    [DEPTH];

  logic [CNT_W:0] credit_used;
  logic           req;
  logic           fire;
  logic           resp;
  logic           drop;
  logic           push;
  logic           pop;
  logic [31:0]    target;
  logic [31:0]    target_al;

  // Handshake qualifiers and redirect target
  always_comb begin
    credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
    req         = !rst_i && !redirect_i && (credit_used < (CNT_W + 1)'(DEPTH));
    fire        = req && imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored
    resp        = imem_rvalid_i && (outstanding_q != '0);
    drop        = resp && (discard_q != '0);
    push        = resp && !drop && !redirect_i;
    pop         = instr_valid_o && instr_ready_i && !redirect_i;
    target      = redirect_base_i + ImmOp_i;
    target_al   = {target[31:2], 2'b00};
  end

  // Next-state for PC, credit counters and buffer pointers
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(resp);
    discard_d     = discard_q - CNT_W'(drop);
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d      = wr_ptr_q + PTR_W'(push);
    misalign_d    = misalign_q;
    if (fire) begin
      pc_d = pc_q + 32'd4;
    end
    if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
    end
    if (redirect_i) begin
      // Everything still in flight after this cycle's response is stale
      pc_d      = target_al;
      resp_pc_d = target_al;
      discard_d = outstanding_d;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      if (target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      misalign_q    <= misalign_d;
    end
  end

  // Instruction buffer storage; contents are qualified by count_q, so no reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata_i;
      buf_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  // Output drive from request logic and buffer head
  always_comb begin
    imem_req_o    = req;
    imem_addr_o   = pc_q;
    instr_valid_o = !rst_i && (count_q != '0);
    instr_o       = buf_instr_q[rd_ptr_q];
    pc_o          = buf_pc_q[rd_ptr_q];
    misalign_o    = misalign_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory responder.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] base;
  logic [31:0] imm;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ready;
  logic        misalign;

  logic        rsp_en;
  logic [7:0]  tag;
  logic [31:0] mq [$];

  int n_pass  = 0;
  int n_total = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_gnt_i     (gnt),
    .imem_rvalid_i  (rvalid),
    .imem_rdata_i   (rdata),
    .redirect_i     (redirect),
    .redirect_base_i(base),
    .ImmOp_i        (imm),
    .instr_valid_o  (valid),
    .instr_o        (instr),
    .pc_o           (pc),
    .instr_ready_i  (ready),
    .misalign_o     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word content depends on address and a generation tag
  function automatic logic [31:0] mw(input logic [31:0] a, input logic [7:0] t);
    return a ^ {8'hA5, t, 16'h0000};
  endfunction

  // In-order responder: data captured at grant, returned one per cycle when enabled
  always @(posedge clk) begin
    if (rsp_en && mq.size() > 0) begin
      rvalid <= 1'b1;
      rdata  <= mq.pop_front();
    end else begin
      rvalid <= 1'b0;
    end
    if (imem_req && gnt) mq.push_back(mw(imem_addr, tag));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; gnt = 1'b0; rsp_en = 1'b1; redirect = 1'b0; ready = 1'b1;
    base = '0; imm = '0; tag = 8'h00;
    repeat (3) tick();
  endtask

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rsp;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t v(input logic r, input logic g, input logic s, input logic d,
                             input logic q, input logic [31:0] a, input logic vl,
                             input logic [31:0] p);
    vec_t x;
    x.rst = r; x.gnt = g; x.rsp = s; x.rdy = d;
    x.req = q; x.addr = a; x.vld = vl; x.pc = p;
    return x;
  endfunction

  vec_t vec [16];

  initial begin
    rvalid = 1'b0;
    rdata  = '0;
    @(negedge clk);
    do_reset();

    // Steady flow with 1-cycle memory, then a ready stall and release
    vec[0]  = v(1, 0, 1, 1, 0, 32'h000, 0, 32'h000);
    vec[1]  = v(0, 1, 1, 1, 1, 32'h100, 0, 32'h000);
    vec[2]  = v(0, 1, 1, 1, 1, 32'h104, 0, 32'h000);
    vec[3]  = v(0, 1, 1, 1, 0, 32'h000, 0, 32'h000);
    vec[4]  = v(0, 1, 1, 1, 0, 32'h000, 1, 32'h100);
    vec[5]  = v(0, 1, 1, 1, 1, 32'h108, 1, 32'h104);
    vec[6]  = v(0, 1, 1, 1, 1, 32'h10C, 0, 32'h000);
    vec[7]  = v(0, 1, 1, 1, 0, 32'h000, 0, 32'h000);
    vec[8]  = v(0, 1, 1, 0, 0, 32'h000, 1, 32'h108);
    vec[9]  = v(0, 1, 1, 0, 0, 32'h000, 1, 32'h108);
    vec[10] = v(0, 1, 1, 1, 0, 32'h000, 1, 32'h108);
    vec[11] = v(0, 1, 1, 1, 1, 32'h110, 1, 32'h10C);
    vec[12] = v(0, 1, 1, 1, 1, 32'h114, 0, 32'h000);
    vec[13] = v(0, 1, 1, 1, 0, 32'h000, 0, 32'h000);
    vec[14] = v(0, 1, 1, 1, 0, 32'h000, 1, 32'h110);
    vec[15] = v(0, 1, 1, 1, 1, 32'h118, 1, 32'h114);

    for (int i = 0; i < 16; i++) begin
      rst = vec[i].rst; gnt = vec[i].gnt; rsp_en = vec[i].rsp; ready = vec[i].rdy;
      #1;
      chk($sformatf("v%0d req", i), 32'(imem_req), 32'(vec[i].req));
      if (vec[i].req) chk($sformatf("v%0d addr", i), imem_addr, vec[i].addr);
      chk($sformatf("v%0d valid", i), 32'(valid), 32'(vec[i].vld));
      if (vec[i].vld) begin
        chk($sformatf("v%0d pc", i), pc, vec[i].pc);
        chk($sformatf("v%0d instr", i), instr, mw(vec[i].pc, 8'h00));
      end
      chk($sformatf("v%0d misalign", i), 32'(misalign), 32'd0);
      tick();
    end

    // Redirect with two requests in flight: both stale words dropped
    do_reset();
    rst = 1'b0; gnt = 1'b1; rsp_en = 1'b0; tag = 8'h11;
    #1; chk("a1 addr", imem_addr, 32'h100); chk("a1 req", 32'(imem_req), 32'd1); tick();
    #1; chk("a2 addr", imem_addr, 32'h104); tick();
    rsp_en = 1'b1; redirect = 1'b1; base = 32'h108; imm = 32'hFFFF_FFF8; tag = 8'h12;
    #1; chk("a3 req", 32'(imem_req), 32'd0); tick();
    redirect = 1'b0;
    #1; chk("a4 req", 32'(imem_req), 32'd0); chk("a4 valid", 32'(valid), 32'd0); tick();
    #1; chk("a5 req", 32'(imem_req), 32'd1); chk("a5 addr", imem_addr, 32'h100);
    chk("a5 valid", 32'(valid), 32'd0); tick();
    #1; chk("a6 addr", imem_addr, 32'h104); chk("a6 valid", 32'(valid), 32'd0); tick();
    #1; chk("a7 valid", 32'(valid), 32'd0); tick();
    #1; chk("a8 valid", 32'(valid), 32'd1); chk("a8 pc", pc, 32'h100);
    chk("a8 instr", instr, mw(32'h100, 8'h12)); tick();
    #1; chk("a9 pc", pc, 32'h104); chk("a9 instr", instr, mw(32'h104, 8'h12)); tick();

    // Redirect coinciding with a response and a pop
    do_reset();
    rst = 1'b0; gnt = 1'b1; rsp_en = 1'b1; tag = 8'h02;
    tick(); tick(); tick();
    redirect = 1'b1; base = 32'h300; imm = 32'h10; tag = 8'h03;
    #1; chk("b4 valid", 32'(valid), 32'd1); chk("b4 rvalid", 32'(rvalid), 32'd1); tick();
    redirect = 1'b0;
    #1; chk("b5 valid", 32'(valid), 32'd0); chk("b5 req", 32'(imem_req), 32'd1);
    chk("b5 addr", imem_addr, 32'h310); tick();
    #1; chk("b6 addr", imem_addr, 32'h314); tick();
    tick();
    #1; chk("b8 valid", 32'(valid), 32'd1); chk("b8 pc", pc, 32'h310);
    chk("b8 instr", instr, mw(32'h310, 8'h03)); tick();

    // Misaligned target sets sticky flag; PC wraps past 0xFFFF_FFFC
    do_reset();
    rst = 1'b0; gnt = 1'b1; rsp_en = 1'b1; tag = 8'h04;
    redirect = 1'b1; base = 32'h200; imm = 32'h6;
    #1; chk("c1 req", 32'(imem_req), 32'd0); chk("c1 misalign", 32'(misalign), 32'd0); tick();
    redirect = 1'b0; gnt = 1'b0;
    #1; chk("c2 misalign", 32'(misalign), 32'd1); chk("c2 addr", imem_addr, 32'h204);
    chk("c2 req", 32'(imem_req), 32'd1); tick();
    redirect = 1'b1; base = 32'hFFFF_FFF0; imm = 32'hC;
    #1; chk("c3 req", 32'(imem_req), 32'd0); tick();
    redirect = 1'b0; gnt = 1'b1;
    #1; chk("c4 addr", imem_addr, 32'hFFFF_FFFC); chk("c4 misalign", 32'(misalign), 32'd1); tick();
    #1; chk("c5 addr", imem_addr, 32'h0000_0000); chk("c5 req", 32'(imem_req), 32'd1); tick();
    #1; chk("c6 req", 32'(imem_req), 32'd0); tick();
    #1; chk("c7 pc", pc, 32'hFFFF_FFFC); chk("c7 instr", instr, mw(32'hFFFF_FFFC, 8'h04)); tick();
    #1; chk("c8 pc", pc, 32'h0000_0000); chk("c8 valid", 32'(valid), 32'd1); tick();

    // Reset mid-stream with two requests outstanding; late responses ignored
    do_reset();
    rst = 1'b0; gnt = 1'b1; rsp_en = 1'b0; tag = 8'h05;
    tick(); tick();
    rst = 1'b1;
    #1; chk("d3 req", 32'(imem_req), 32'd0); chk("d3 valid", 32'(valid), 32'd0); tick();
    rst = 1'b0; gnt = 1'b0; rsp_en = 1'b1; tag = 8'h06;
    #1; chk("d4 addr", imem_addr, 32'h100); chk("d4 misalign", 32'(misalign), 32'd0); tick();
    #1; chk("d5 rvalid", 32'(rvalid), 32'd1); chk("d5 valid", 32'(valid), 32'd0); tick();
    gnt = 1'b1;
    #1; chk("d6 valid", 32'(valid), 32'd0); chk("d6 addr", imem_addr, 32'h100); tick();
    gnt = 1'b0;
    #1; chk("d7 valid", 32'(valid), 32'd0); chk("d7 addr", imem_addr, 32'h104); tick();
    #1; chk("d8 valid", 32'(valid), 32'd0); tick();
    #1; chk("d9 valid", 32'(valid), 32'd1); chk("d9 pc", pc, 32'h100);
    chk("d9 instr", instr, mw(32'h100, 8'h06));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
